// File: rtl/reg_dbg_scanner_pkg.sv
// Shared types and constants for the register-file debug scanner.
// Address/data widths match the CPU debug port; the state enum is also
// exported on the debug port of the scanner interface.
package reg_dbg_scanner_pkg;

   localparam int REG_ADRS_W = 5;
   localparam int REG_DATA_W = 32;

   typedef logic [REG_ADRS_W-1:0] adrs_t;
   typedef logic [REG_DATA_W-1:0] data_t;

   // Scanner FSM states
   typedef enum logic [1:0] {
      SCN_IDLE    = 2'd0,  // waiting for start
      SCN_WAIT    = 2'd1,  // read-latency counter running
      SCN_PRESENT = 2'd2,  // out_valid held until out_ready
      SCN_DONE    = 2'd3   // one-cycle done pulse
   } scn_state_t;

   // Single-register requests beyond the register file read the last register.
   function automatic adrs_t clamp_adrs(input adrs_t a, input int unsigned nregs);
      if (32'(a) >= nregs) begin
         return adrs_t'(nregs - 1);
      end
      return a;
   endfunction

endpackage

// File: rtl/reg_dbg_scanner_if.sv
// Bundle of the scanner's control, CPU debug port and output stream.
//
// Output stream handshake: out_valid/out_adrs/out_data are driven by the
// scanner; once out_valid is high, it and the payload stay constant until
// the consumer raises out_ready. A word moves on the clock edge where
// out_valid and out_ready are both high; out_ready may be high at any time
// and does not depend on out_valid.
interface reg_dbg_scanner_if;
   import reg_dbg_scanner_pkg::*;

   // control
   logic       start;
   logic       single;
   adrs_t      sel_adrs;
   logic       busy;
   logic       done;
   data_t      checksum;
   // CPU debug port
   adrs_t      reg_dbg_adrs;
   data_t      reg_dbg_q;
   // output stream
   logic       out_valid;
   logic       out_ready;
   adrs_t      out_adrs;
   data_t      out_data;
   // FSM state for observation
   scn_state_t dbg_state;

   // scanner side
   modport master (
      input  start, single, sel_adrs, reg_dbg_q, out_ready,
      output busy, done, checksum, reg_dbg_adrs,
      output out_valid, out_adrs, out_data, dbg_state
   );

   // environment side (control source, CPU debug port, consumer)
   modport slave (
      output start, single, sel_adrs, reg_dbg_q, out_ready,
      input  busy, done, checksum, reg_dbg_adrs,
      input  out_valid, out_adrs, out_data, dbg_state
   );

endinterface

// File: rtl/reg_dbg_scanner.sv
// Register-file debug scanner. On start it walks the CPU debug port
// through every register (or reads one selected register), waits RD_LAT
// edges per address, and presents each captured word on a valid/ready
// stream while accumulating an XOR checksum of the transferred words.
module reg_dbg_scanner
   import reg_dbg_scanner_pkg::*;
#(
   parameter int NREGS  = 32,  // registers scanned, 1..32
   parameter int RD_LAT = 1    // edges from address change to valid data
) (
   input  logic          clk_cpu,
   input  logic          reset,
   reg_dbg_scanner_if.master bus
);

   localparam adrs_t      LAST_ADRS = adrs_t'(NREGS - 1);
   localparam logic [7:0] CNT_LOAD  = 8'(RD_LAT);

   scn_state_t state_q;
   logic       single_q;
   adrs_t      adrs_q;
   logic [7:0] cnt_q;
   logic       valid_q;
   adrs_t      out_adrs_q;
   data_t      data_q;
   data_t      chk_q;
   logic       busy_q;
   logic       done_q;

   adrs_t      first_adrs_d;
   adrs_t      next_adrs_d;
   logic       last_word_d;
   logic       xfer_d;

   // Start address, successor address and end-of-scan decode.
   always_comb begin
      first_adrs_d = bus.single ? clamp_adrs(bus.sel_adrs, NREGS) : '0;
      next_adrs_d  = adrs_q + 5'd1;
      last_word_d  = single_q || (adrs_q == LAST_ADRS);
      xfer_d       = valid_q && bus.out_ready;
   end

   // Scanner FSM with all datapath registers; every output is registered.
   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         state_q    <= SCN_IDLE;
         single_q   <= 1'b0;
         adrs_q     <= '0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         out_adrs_q <= '0;
         data_q     <= '0;
         chk_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            SCN_IDLE: begin
               if (bus.start) begin
                  single_q <= bus.single;
                  adrs_q   <= first_adrs_d;
                  chk_q    <= '0;
                  cnt_q    <= CNT_LOAD;
                  busy_q   <= 1'b1;
                  state_q  <= SCN_WAIT;
               end
            end
            SCN_WAIT: begin
               if (cnt_q == 8'd0) begin
                  data_q     <= bus.reg_dbg_q;
                  out_adrs_q <= adrs_q;
                  valid_q    <= 1'b1;
                  state_q    <= SCN_PRESENT;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            SCN_PRESENT: begin
               // address and payload stay frozen while the consumer stalls
               if (xfer_d) begin
                  chk_q   <= chk_q ^ data_q;
                  valid_q <= 1'b0;
                  if (last_word_d) begin
                     done_q  <= 1'b1;
                     state_q <= SCN_DONE;
                  end else begin
                     adrs_q  <= next_adrs_d;
                     cnt_q   <= CNT_LOAD;
                     state_q <= SCN_WAIT;
                  end
               end
            end
            SCN_DONE: begin
               // start is not looked at here, so a request in this cycle is dropped
               busy_q  <= 1'b0;
               state_q <= SCN_IDLE;
            end
            default: begin
               state_q <= SCN_IDLE;
            end
         endcase
      end
   end

   assign bus.reg_dbg_adrs = adrs_q;
   assign bus.out_valid    = valid_q;
   assign bus.out_adrs     = out_adrs_q;
   assign bus.out_data     = data_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.checksum     = chk_q;
   assign bus.dbg_state    = state_q;

   // A stalled word must not change under the consumer.
   a_hold_stalled: assert property (@(posedge clk_cpu) disable iff (reset)
      (valid_q && !bus.out_ready) |=>
         (valid_q && $stable(data_q) && $stable(out_adrs_q) && $stable(adrs_q)));

   // done is a single-cycle pulse.
   a_done_pulse: assert property (@(posedge clk_cpu) disable iff (reset)
      done_q |=> !done_q);

endmodule

// File: tb/tb_reg_dbg_scanner.sv
// Bench for reg_dbg_scanner: one instance with RD_LAT=1 (port 1) and one
// with RD_LAT=0 (port 0), each next to a register-file model holding
// 32'h1000_0000+i. A timing model predicts every output each cycle from
// the start/transfer events; directed scenarios add literal expectations.
module tb_reg_dbg_scanner;
   import reg_dbg_scanner_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk_cpu = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_cpu = ~clk_cpu;

   int cyc = 0;
   always @(posedge clk_cpu) cyc <= cyc + 1;

   reg_dbg_scanner_if bus0();
   reg_dbg_scanner_if bus1();

   reg_dbg_scanner #(.NREGS(32), .RD_LAT(0)) dut0 (
      .clk_cpu(clk_cpu), .reset(reset), .bus(bus0));
   reg_dbg_scanner #(.NREGS(32), .RD_LAT(1)) dut1 (
      .clk_cpu(clk_cpu), .reset(reset), .bus(bus1));

   // register files: combinational for port 0, one-edge latency for port 1
   assign bus0.reg_dbg_q = 32'h1000_0000 + {27'd0, bus0.reg_dbg_adrs};
   always @(posedge clk_cpu) bus1.reg_dbg_q <= 32'h1000_0000 + {27'd0, bus1.reg_dbg_adrs};

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] word(input logic [4:0] a);
      return 32'h1000_0000 + {27'd0, a};
   endfunction

   // ---------------- behavioural model + scoreboard ----------------
   int          m_lat[2] = '{0, 1};
   bit          m_active[2], m_finishing[2], m_single[2];
   int          m_valid_at[2], m_end_cyc[2];
   int          m_done_cyc[2] = '{-1, -1};
   logic [4:0]  m_cur[2], m_dbg[2], m_oadrs[2];
   logic [31:0] m_odata[2], m_chk[2];
   logic [36:0] exp_q0[$];
   logic [36:0] exp_q1[$];
   int          xc0[$];
   int          xc1[$];
   int          done_n[2];

   task automatic sb_push(input int p, input logic [4:0] a);
      if (p == 0) exp_q0.push_back({a, word(a)});
      else        exp_q1.push_back({a, word(a)});
   endtask

   task automatic step(input int p, input logic rst, input logic st, input logic sg,
                       input logic [4:0] sel, input logic rdy, input logic valid,
                       input logic busy, input logic done, input logic [4:0] dbg,
                       input logic [4:0] oadrs, input logic [31:0] odata,
                       input logic [31:0] chk);
      bit          valid_e;
      int          u;
      logic [36:0] e;
      valid_e = m_active[p] && !m_finishing[p] && (cyc >= m_valid_at[p]);
      check($sformatf("p%0d out_valid", p), {31'd0, valid}, {31'd0, valid_e});
      check($sformatf("p%0d busy", p), {31'd0, busy}, {31'd0, m_active[p]});
      check($sformatf("p%0d done", p), {31'd0, done}, {31'd0, (cyc == m_done_cyc[p])});
      check($sformatf("p%0d reg_dbg_adrs", p), {27'd0, dbg}, {27'd0, m_dbg[p]});
      check($sformatf("p%0d out_adrs", p), {27'd0, oadrs}, {27'd0, m_oadrs[p]});
      check($sformatf("p%0d out_data", p), odata, m_odata[p]);
      check($sformatf("p%0d checksum", p), chk, m_chk[p]);
      if (done === 1'b1) done_n[p]++;
      // observed transfer against the expected word queue
      if (valid === 1'b1 && rdy && !rst) begin
         if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL p%0d unexpected transfer: got adrs %0d expected none", p, oadrs);
         end else begin
            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("p%0d sb adrs", p), {27'd0, oadrs}, {27'd0, e[36:32]});
            check($sformatf("p%0d sb data", p), odata, e[31:0]);
         end
         if (p == 0) xc0.push_back(cyc + 1);
         else        xc1.push_back(cyc + 1);
      end
      // advance model to the next edge
      u = cyc + 1;
      if (rst) begin
         m_active[p] = 0; m_finishing[p] = 0; m_single[p] = 0;
         m_cur[p] = '0; m_dbg[p] = '0; m_oadrs[p] = '0; m_odata[p] = '0; m_chk[p] = '0;
         m_done_cyc[p] = -1;
         if (p == 0) exp_q0.delete();
         else        exp_q1.delete();
      end else if (!m_active[p]) begin
         if (st) begin
            m_active[p]    = 1;
            m_finishing[p] = 0;
            m_single[p]    = sg;
            m_cur[p]       = sg ? sel : 5'd0;
            m_dbg[p]       = m_cur[p];
            m_chk[p]       = '0;
            m_valid_at[p]  = u + 1 + m_lat[p];
            if (sg) sb_push(p, sel);
            else for (int i = 0; i < 32; i++) sb_push(p, 5'(i));
         end
      end else begin
         if (valid_e && rdy) begin
            m_chk[p] = m_chk[p] ^ word(m_cur[p]);
            if (!m_single[p] && m_cur[p] != 5'd31) begin
               m_cur[p]      = m_cur[p] + 5'd1;
               m_dbg[p]      = m_cur[p];
               m_valid_at[p] = u + 1 + m_lat[p];
            end else begin
               m_finishing[p] = 1;
               m_done_cyc[p]  = u;
               m_end_cyc[p]   = u + 1;
            end
         end else if (m_finishing[p] && u == m_end_cyc[p]) begin
            m_active[p]    = 0;
            m_finishing[p] = 0;
         end
         if (m_active[p] && !m_finishing[p] && u == m_valid_at[p]) begin
            m_oadrs[p] = m_cur[p];
            m_odata[p] = word(m_cur[p]);
         end
      end
   endtask

   // compare process: outputs are stable at the falling edge
   always @(negedge clk_cpu) begin
      step(0, reset, bus0.start, bus0.single, bus0.sel_adrs, bus0.out_ready, bus0.out_valid,
           bus0.busy, bus0.done, bus0.reg_dbg_adrs, bus0.out_adrs, bus0.out_data, bus0.checksum);
      step(1, reset, bus1.start, bus1.single, bus1.sel_adrs, bus1.out_ready, bus1.out_valid,
           bus1.busy, bus1.done, bus1.reg_dbg_adrs, bus1.out_adrs, bus1.out_data, bus1.checksum);
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_cpu);
         #1;
      end
   endtask

   task automatic drive(input int p, input logic st, input logic sg, input logic [4:0] sel);
      if (p == 0) begin bus0.start = st; bus0.single = sg; bus0.sel_adrs = sel; end
      else        begin bus1.start = st; bus1.single = sg; bus1.sel_adrs = sel; end
   endtask

   // returns the edge at which start is sampled
   task automatic pulse_start(input int p, input logic sg, input logic [4:0] sel, output int t);
      drive(p, 1'b1, sg, sel);
      t = cyc + 1;
      tick(1);
      drive(p, 1'b0, 1'b0, 5'd0);
   endtask

   function automatic logic busy_of(input int p);
      return (p == 0) ? bus0.busy : bus1.busy;
   endfunction

   task automatic wait_idle(input int p, output int fall);
      int budget;
      budget = 400;
      while (busy_of(p) === 1'b1 && budget > 0) begin
         tick(1);
         budget--;
      end
      if (budget == 0) begin
         checks++;
         errors++;
         $display("FAIL p%0d busy timeout: got busy=1 expected 0 within 400 cycles", p);
      end
      fall = cyc;
   endtask

   task automatic wait_word(input logic [4:0] a);
      int budget;
      budget = 200;
      while (!(bus1.out_valid === 1'b1 && bus1.out_adrs == a) && budget > 0) begin
         tick(1);
         budget--;
      end
      if (budget == 0) begin
         checks++;
         errors++;
         $display("FAIL wait word: got no out_valid at adrs %0d expected one within 200 cycles", a);
      end
   endtask

   task automatic clear_log;
      xc0.delete();
      xc1.delete();
      done_n[0] = 0;
      done_n[1] = 0;
   endtask

   // full-scan checks shared by scenarios 1 and 6
   task automatic full_scan(input int p, input int period, input int dur);
      int t, f;
      clear_log();
      pulse_start(p, 1'b0, 5'd0, t);
      wait_idle(p, f);
      check($sformatf("p%0d scan duration", p), f - t, dur);
      if (p == 0) begin
         check("p0 transfers", xc0.size(), 32);
         if (xc0.size() > 0) check("p0 first offset", xc0[0] - t, period);
         for (int i = 1; i < xc0.size(); i++) check("p0 gap", xc0[i] - xc0[i-1], period);
         check("p0 checksum", bus0.checksum, 32'h0000_0000);
         check("p0 last data", bus0.out_data, 32'h1000_001F);
      end else begin
         check("p1 transfers", xc1.size(), 32);
         if (xc1.size() > 0) check("p1 first offset", xc1[0] - t, period);
         for (int i = 1; i < xc1.size(); i++) check("p1 gap", xc1[i] - xc1[i-1], period);
         check("p1 checksum", bus1.checksum, 32'h0000_0000);
         check("p1 last data", bus1.out_data, 32'h1000_001F);
      end
      check($sformatf("p%0d done pulses", p), done_n[p], 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t, f, budget;
      drive(0, 1'b0, 1'b0, 5'd0);
      drive(1, 1'b0, 1'b0, 5'd0);
      bus0.out_ready = 1'b1;
      bus1.out_ready = 1'b1;
      reset = 1'b1;
      tick(3);
      check("reset busy", {31'd0, bus1.busy}, 32'd0);
      check("reset out_valid", {31'd0, bus1.out_valid}, 32'd0);
      check("reset done", {31'd0, bus1.done}, 32'd0);
      check("reset checksum", bus1.checksum, 32'd0);
      check("reset out_data", bus1.out_data, 32'd0);
      check("reset reg_dbg_adrs", {27'd0, bus1.reg_dbg_adrs}, 32'd0);
      reset = 1'b0;
      tick(2);

      // 1: full scan, RD_LAT=1
      full_scan(1, 3, 97);
      tick(2);

      // 2: backpressure on word 3
      clear_log();
      pulse_start(1, 1'b0, 5'd0, t);
      wait_word(5'd3);
      bus1.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp out_valid", {31'd0, bus1.out_valid}, 32'd1);
         check("bp out_data", bus1.out_data, 32'h1000_0003);
         check("bp reg_dbg_adrs", {27'd0, bus1.reg_dbg_adrs}, 32'd3);
         tick(1);
      end
      bus1.out_ready = 1'b1;
      wait_idle(1, f);
      check("bp duration", f - t, 102);
      check("bp transfers", xc1.size(), 32);
      check("bp checksum", bus1.checksum, 32'h0000_0000);
      tick(2);

      // 3: single read of register 7
      clear_log();
      pulse_start(1, 1'b1, 5'd7, t);
      wait_idle(1, f);
      check("single transfers", xc1.size(), 1);
      check("single out_data", bus1.out_data, 32'h1000_0007);
      check("single out_adrs", {27'd0, bus1.out_adrs}, 32'd7);
      check("single checksum", bus1.checksum, 32'h1000_0007);
      check("single duration", f - t, 4);
      check("single done pulses", done_n[1], 1);
      tick(2);

      // 4: reset during word 10
      clear_log();
      pulse_start(1, 1'b0, 5'd0, t);
      wait_word(5'd10);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("rst busy", {31'd0, bus1.busy}, 32'd0);
      check("rst out_valid", {31'd0, bus1.out_valid}, 32'd0);
      check("rst done", {31'd0, bus1.done}, 32'd0);
      check("rst checksum", bus1.checksum, 32'd0);
      check("rst out_data", bus1.out_data, 32'd0);
      check("rst out_adrs", {27'd0, bus1.out_adrs}, 32'd0);
      check("rst reg_dbg_adrs", {27'd0, bus1.reg_dbg_adrs}, 32'd0);
      tick(4);
      check("rst no done", done_n[1], 0);
      pulse_start(1, 1'b0, 5'd0, t);
      budget = 20;
      while (bus1.out_valid !== 1'b1 && budget > 0) begin
         tick(1);
         budget--;
      end
      check("rst restart first adrs", {27'd0, bus1.out_adrs}, 32'd0);
      check("rst restart latency", cyc - t, 2);
      wait_idle(1, f);
      tick(2);

      // 5: start while busy and in the done cycle
      clear_log();
      pulse_start(1, 1'b0, 5'd0, t);
      wait_word(5'd5);
      pulse_start(1, 1'b0, 5'd0, f);
      budget = 200;
      while (bus1.done !== 1'b1 && budget > 0) begin
         tick(1);
         budget--;
      end
      check("ign done seen", {31'd0, bus1.done}, 32'd1);
      pulse_start(1, 1'b0, 5'd0, f);
      tick(5);
      check("ign busy after", {31'd0, bus1.busy}, 32'd0);
      check("ign transfers", xc1.size(), 32);
      check("ign done pulses", done_n[1], 1);
      tick(2);

      // 6: full scan, RD_LAT=0
      full_scan(0, 2, 65);
      tick(2);

      check("p0 queue drained", exp_q0.size(), 0);
      check("p1 queue drained", exp_q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000ns");
      $fatal(1, "watchdog");
   end

endmodule
